// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared constants, entry type and helpers for demux5_32_wb
package demux_pkg;

    localparam int NUM_DEST   = 5;
    localparam int FIFO_DEPTH = 2;
    localparam int SEL_W      = 3;
    localparam int DATA_W     = 32;

    localparam logic [SEL_W-1:0] SEL_A = 3'd0;
    localparam logic [SEL_W-1:0] SEL_B = 3'd1;
    localparam logic [SEL_W-1:0] SEL_C = 3'd2;
    localparam logic [SEL_W-1:0] SEL_D = 3'd3;
    localparam logic [SEL_W-1:0] SEL_E = 3'd4;

    // One buffered write-back word together with its destination code.
    typedef struct packed {
        logic [SEL_W-1:0]  sel;
        logic [DATA_W-1:0] data;
    } entry_t;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_t;

    // Codes above SEL_E address no destination and are dropped.
    function automatic logic sel_is_valid(input logic [SEL_W-1:0] s);
        return (s <= SEL_E);
    endfunction

endpackage

// File: rtl/demux5_32_wb_if.sv
// rtl/demux5_32_wb_if.sv - input handshake and destination bus of demux5_32_wb
interface demux5_32_wb_if;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [2:0]  in_sel;

    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] c_q;
    logic [31:0] d_q;
    logic [31:0] e_q;
    logic [4:0]  out_valid;
    logic [4:0]  out_ack;

    // Source of words and consumer of destination registers.
    modport master (
        output in_valid, in_data, in_sel, out_ack,
        input  in_ready, a_q, b_q, c_q, d_q, e_q, out_valid
    );

    // The demultiplexer itself.
    modport slave (
        input  in_valid, in_data, in_sel, out_ack,
        output in_ready, a_q, b_q, c_q, d_q, e_q, out_valid
    );

endinterface

// File: rtl/fifo2_35.sv
// rtl/fifo2_35.sv - 2-entry in-order FIFO of {sel,data} entries
module fifo2_35
    import demux_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push,
    input  logic   pop,
    input  entry_t wdata,
    output entry_t rdata,
    output logic   full,
    output logic   empty
);

    occ_t   state;
    occ_t   state_nxt;
    entry_t mem [FIFO_DEPTH];
    logic   wr_ptr;
    logic   rd_ptr;
    logic   do_push;
    logic   do_pop;

    // Overflow and underflow requests are ignored rather than corrupting order.
    assign do_push = push && (state != OCC_FULL);
    assign do_pop  = pop  && (state != OCC_EMPTY);

    // Occupancy register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= OCC_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Occupancy next state: push advances, pop retreats, both hold.
    always_comb begin
        state_nxt = state;
        case ({do_push, do_pop})
            2'b10: begin
                case (state)
                    OCC_EMPTY: state_nxt = OCC_ONE;
                    OCC_ONE:   state_nxt = OCC_FULL;
                    default:   state_nxt = state;
                endcase
            end
            2'b01: begin
                case (state)
                    OCC_FULL: state_nxt = OCC_ONE;
                    OCC_ONE:  state_nxt = OCC_EMPTY;
                    default:  state_nxt = state;
                endcase
            end
            default: state_nxt = state;
        endcase
    end

    // Storage and read/write pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            mem[0] <= '0;
            mem[1] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
        end
    end

    assign rdata = mem[rd_ptr];
    assign full  = (state == OCC_FULL);
    assign empty = (state == OCC_EMPTY);

endmodule

// File: rtl/demux5_32_wb.sv
// rtl/demux5_32_wb.sv - buffered 5-way write-back demux; err_cnt under DEMUX5_32_WB_ERRCNT_EN
module demux5_32_wb
    import demux_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    demux5_32_wb_if.slave    bus
`ifdef DEMUX5_32_WB_ERRCNT_EN
    ,
    output logic [7:0]       err_cnt
`endif
);

    entry_t              head;
    entry_t              wdata;
    logic                fifo_full;
    logic                fifo_empty;
    logic                push;
    logic                pop;
    logic                armed;
    logic                head_ok;
    logic [NUM_DEST-1:0] sel_oh;
    logic [NUM_DEST-1:0] dest_free;
    logic [NUM_DEST-1:0] load;
    logic [NUM_DEST-1:0] out_valid_r;
    logic [DATA_W-1:0]   dq [NUM_DEST];

    // armed stays low until the first edge after reset release so a word
    // held on the input during reset is not taken on that edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed <= 1'b0;
        end else begin
            armed <= 1'b1;
        end
    end

    // Readiness depends only on stored occupancy, never on this cycle's pop.
    assign bus.in_ready = armed && !fifo_full;
    assign push         = bus.in_valid && bus.in_ready;
    assign wdata        = '{sel: bus.in_sel, data: bus.in_data};

    fifo2_35 u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (wdata),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign head_ok   = sel_is_valid(head.sel);
    assign dest_free = ~out_valid_r | bus.out_ack;

    // Head dispatch: invalid codes drop at once, valid ones wait for their destination.
    always_comb begin
        sel_oh = '0;
        pop    = 1'b0;
        load   = '0;
        for (int k = 0; k < NUM_DEST; k++) begin
            if (head.sel == 3'(k)) begin
                sel_oh[k] = 1'b1;
            end
        end
        if (!fifo_empty) begin
            if (!head_ok) begin
                pop = 1'b1;
            end else if (|(sel_oh & dest_free)) begin
                pop  = 1'b1;
                load = sel_oh;
            end
        end
    end

    // Destination data registers keep their last word after consumption.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_DEST; k++) begin
                dq[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_DEST; k++) begin
                if (load[k]) begin
                    dq[k] <= head.data;
                end
            end
        end
    end

    // Valid flags: a load on the same edge wins over an acknowledge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= '0;
        end else begin
            out_valid_r <= load | (out_valid_r & ~bus.out_ack);
        end
    end

    assign bus.out_valid = out_valid_r;
    assign bus.a_q       = dq[0];
    assign bus.b_q       = dq[1];
    assign bus.c_q       = dq[2];
    assign bus.d_q       = dq[3];
    assign bus.e_q       = dq[4];

`ifdef DEMUX5_32_WB_ERRCNT_EN
    logic drop;
    assign drop = !fifo_empty && !head_ok;

    // Saturating count of dropped invalid-code words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= 8'd0;
        end else if (drop && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_demux5_32_wb.sv
// tb/tb_demux5_32_wb.sv - randomized and directed bench for demux5_32_wb with reference model
module tb_demux5_32_wb;
    import demux_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    demux5_32_wb_if bus();
`ifdef DEMUX5_32_WB_ERRCNT_EN
    logic [7:0] err_cnt;
`endif

    demux5_32_wb dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef DEMUX5_32_WB_ERRCNT_EN
        ,
        .err_cnt (err_cnt)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of pending words and per-destination slots.
    entry_t      mq[$];
    logic [4:0]  m_vld;
    logic [31:0] m_q [5];
    int          m_err;
    bit          m_armed;
    int          m_n;
    int          m_s;
    logic [4:0]  m_ld;
    bit          m_acc;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_vld   = '0;
            for (int k = 0; k < 5; k++) m_q[k] = '0;
            m_err   = 0;
            m_armed = 0;
        end else begin
            m_n   = mq.size();
            m_ld  = '0;
            m_acc = bus.in_valid && m_armed && (m_n < 2);
            if (m_n > 0) begin
                m_s = int'(mq[0].sel);
                if (m_s > 4) begin
                    void'(mq.pop_front());
                    if (m_err < 255) m_err++;
                end else if (!m_vld[m_s] || bus.out_ack[m_s]) begin
                    m_ld[m_s]  = 1'b1;
                    m_q[m_s]   = mq[0].data;
                    void'(mq.pop_front());
                end
            end
            for (int k = 0; k < 5; k++) begin
                if (m_ld[k]) m_vld[k] = 1'b1;
                else if (bus.out_ack[k]) m_vld[k] = 1'b0;
            end
            if (m_acc) mq.push_back('{sel: bus.in_sel, data: bus.in_data});
            m_armed = 1;
        end
    end

    logic [31:0] dut_q [5];
    assign dut_q[0] = bus.a_q;
    assign dut_q[1] = bus.b_q;
    assign dut_q[2] = bus.c_q;
    assign dut_q[3] = bus.d_q;
    assign dut_q[4] = bus.e_q;

    bit chk_on = 0;

    always @(negedge clk) begin
        if (chk_on && rst_n) begin
            chk("in_ready", 32'(bus.in_ready), 32'(m_armed && (mq.size() < 2)));
            chk("out_valid", 32'(bus.out_valid), 32'(m_vld));
            for (int k = 0; k < 5; k++) begin
                chk($sformatf("dest_q[%0d]", k), dut_q[k], m_q[k]);
            end
`ifdef DEMUX5_32_WB_ERRCNT_EN
            chk("err_cnt", 32'(err_cnt), 32'(m_err));
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        bus.in_valid = 1'b0;
        bus.in_sel   = 3'd0;
        bus.in_data  = 32'd0;
        bus.out_ack  = 5'd0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic send(input logic [2:0] s, input logic [31:0] d);
        bus.in_valid = 1'b1;
        bus.in_sel   = s;
        bus.in_data  = d;
        step();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        step();
        step();
        chk("rst out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst a_q", bus.a_q, 32'd0);
        rst_n = 1'b1;
        step();
        chk("rst in_ready", 32'(bus.in_ready), 32'd1);
        chk_on = 1;

        // Single word to c with the two-edge latency.
        do_reset();
        bus.in_valid = 1'b1; bus.in_sel = SEL_C; bus.in_data = 32'hDEADBEEF;
        step();
        bus.in_valid = 1'b0;
        chk("single lat1", 32'(bus.out_valid), 32'd0);
        step();
        chk("single c_q", bus.c_q, 32'hDEADBEEF);
        chk("single out_valid", 32'(bus.out_valid), 32'h4);
        chk("model c_q", m_q[2], 32'hDEADBEEF);

        // Head-of-line blocking on destination a.
        do_reset();
        send(SEL_A, 32'h1111_0001);
        send(SEL_A, 32'h1111_0002);
        send(SEL_B, 32'h2222_0003);
        chk("block in_ready", 32'(bus.in_ready), 32'd0);
        chk("block model full", 32'(mq.size()), 32'd2);
        repeat (3) step();
        chk("block b idle", 32'(bus.out_valid), 32'h1);
        bus.out_ack = 5'b00001;
        step();
        bus.out_ack = 5'b00000;
        chk("block a_q w2", bus.a_q, 32'h1111_0002);
        chk("block ov a", 32'(bus.out_valid), 32'h1);
        step();
        chk("block b_q w3", bus.b_q, 32'h2222_0003);
        chk("block ov ab", 32'(bus.out_valid), 32'h3);

        // Ack and reload on the same edge keep d valid.
        do_reset();
        send(SEL_D, 32'hD000_0001);
        step();
        chk("reload ov d", 32'(bus.out_valid), 32'h8);
        send(SEL_D, 32'hD000_0002);
        bus.out_ack = 5'b01000;
        step();
        bus.out_ack = 5'b00000;
        chk("reload ov", 32'(bus.out_valid), 32'h8);
        chk("reload d_q", bus.d_q, 32'hD000_0002);

        // Invalid codes drop in one cycle; counter saturates.
        do_reset();
        send(SEL_A, 32'hA5A5_A5A5);
        step();
        send(3'b110, 32'hBAD0_0001);
        step();
        chk("inv ov", 32'(bus.out_valid), 32'h1);
        chk("inv drained", 32'(mq.size()), 32'd0);
        chk("inv a_q", bus.a_q, 32'hA5A5_A5A5);
`ifdef DEMUX5_32_WB_ERRCNT_EN
        chk("inv err 1", 32'(err_cnt), 32'd1);
`endif
        bus.in_valid = 1'b1;
        repeat (300) begin
            bus.in_sel  = 3'($urandom_range(5, 7));
            bus.in_data = $urandom;
            step();
        end
        bus.in_valid = 1'b0;
        step();
        step();
        chk("inv model sat", 32'(m_err), 32'd255);
`ifdef DEMUX5_32_WB_ERRCNT_EN
        chk("inv err sat", 32'(err_cnt), 32'd255);
`endif

        // Reset in the middle of a blocked, full state.
        do_reset();
        send(SEL_A, 32'hA000_0001);
        send(SEL_E, 32'hE000_0002);
        send(SEL_A, 32'hA000_0003);
        send(SEL_E, 32'hE000_0004);
        chk("mid ov", 32'(bus.out_valid), 32'h11);
        chk("mid full", 32'(bus.in_ready), 32'd0);
        bus.in_valid = 1'b1; bus.in_sel = SEL_A; bus.in_data = 32'hFFFF_0000;
        rst_n = 1'b0;
        #1;
        chk("mid rst ov", 32'(bus.out_valid), 32'd0);
        chk("mid rst a_q", bus.a_q, 32'd0);
        chk("mid rst e_q", bus.e_q, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        bus.in_valid = 1'b0;
        chk("mid rel ready", 32'(bus.in_ready), 32'd1);
        repeat (3) step();
        chk("mid no dispatch", 32'(bus.out_valid), 32'd0);
        chk("mid a_q", bus.a_q, 32'd0);

        // Back-to-back stream to all five destinations.
        do_reset();
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.in_sel  = 3'(i);
            bus.in_data = 32'hC0DE_0000 + 32'(i);
            step();
        end
        bus.in_valid = 1'b0;
        chk("stream 5 edges", 32'(bus.out_valid), 32'h0F);
        step();
        chk("stream 6 edges", 32'(bus.out_valid), 32'h1F);
        chk("stream e_q", bus.e_q, 32'hC0DE_0004);

        // Random traffic against the model.
        do_reset();
        repeat (3000) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.in_sel   = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            bus.in_data  = $urandom;
            bus.out_ack  = 5'($urandom_range(0, 31));
            step();
        end
        idle_inputs();
        repeat (4) step();

        chk_on = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
